sn_window_decoder: RTL and testbench
====================================

# sn_window_decoder

Downstream stage of the stochastic multiplier: consumes the serial stochastic bitstream (one product bit per qualified cycle) and converts it back to binary by counting ones over a programmable window of 2^L bits. It presents a window-normalised unipolar probability and, optionally, the bipolar signed value, through a valid/ready output handshake. It replaces ad-hoc free-running ones-counters with a well-defined, overflow-free window.

## Interface
- `MAX_LOG2`, default 8: largest window exponent; also the output fraction width (Q0.MAX_LOG2).
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `sn_bit` input 1: stochastic stream bit.
- `sn_valid` input 1: `sn_bit` is counted only in cycles where this is 1.
- `start` input 1: begin a window; honoured only in IDLE.
- `cont` input 1: sampled at window end; 1 means re-arm automatically after handshake.
- `win_sel` input 4: window exponent L, latched on accepted start; values > `MAX_LOG2` are clamped to `MAX_LOG2`.
- `busy` output 1: high in COUNT and DONE.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts result.
- `prob_out` output MAX_LOG2+1: ones count scaled to 2^MAX_LOG2 full-scale.
- `bip_out` output MAX_LOG2+2, signed: bipolar value (see Configuration).

## Operation
- States: IDLE, COUNT, DONE.
- IDLE: counters cleared. `start`=1 latches clamped L into `win_len`, clears `bits_seen` and `ones`, goes to COUNT.
- COUNT: each cycle with `sn_valid`=1, `bits_seen`+=1 and `ones`+=`sn_bit`. When the increment makes `bits_seen` equal 2^L, latch `prob_out` = `ones_next` << (MAX_LOG2-L), latch `cont` into `cont_q`, go to DONE. Cycles with `sn_valid`=0 change nothing.
- Counter widths are MAX_LOG2+1, so an all-ones window gives `prob_out` = 2^MAX_LOG2 without wrap. There is no overflow path.
- DONE: `out_valid`=1; `prob_out`/`bip_out` are held stable until `out_ready`=1.
- On handshake:
  - If `cont_q`=1: go to COUNT with the same L and cleared counters. Stream bits arriving in the handshake cycle are not counted.
  - Otherwise: go to IDLE.
- `start` in COUNT or DONE is ignored. `win_sel` changes take effect only at the next accepted start.
- L=0: the window is one bit; `prob_out` is 0 or 2^MAX_LOG2.

## Timing
- Reset: state IDLE; `busy`=0, `out_valid`=0, `prob_out`=0, `bip_out`=0; internal counters 0.
- Reset asserted mid-window or in DONE aborts at the next edge. The partial count is discarded and no result is emitted.
- Start latency: `start` high at edge N → COUNT from N; the first bit counted is at edge N+1.
- Result latency: the final qualified bit is sampled at edge M → `out_valid`=1 after edge M (visible in cycle M+1).
- `out_ready` high while `out_valid`=0 has no effect.
- Continuous mode: one dead cycle per window (the handshake cycle). Window k+1 counts from the edge after the handshake.
- `out_valid`, `busy` and all data outputs are registered; no combinational path from inputs.

## Configuration
- `SN_BIPOLAR_EN` defined: `bip_out` = 2*`prob_out` − 2^MAX_LOG2, registered alongside `prob_out`. Range is −2^MAX_LOG2 … +2^MAX_LOG2, matching XNOR-multiplier bipolar encoding.
- `SN_BIPOLAR_EN` undefined: `bip_out` is tied to 0 and no bipolar arithmetic is synthesised. All other behaviour is identical.

## Test plan
All scenarios use MAX_LOG2=8.
- Reset then idle: `rst_n`=0 for 2 cycles, then 1 with no start → `busy`=0, `out_valid`=0, `prob_out`=0 indefinitely.
- Unipolar count: start, `win_sel`=4, 16 qualified bits of which 5 are ones, `out_ready`=1 → `out_valid` one cycle after the 16th bit, `prob_out`=80; with `SN_BIPOLAR_EN`, `bip_out`=−96.
- Gaps and backpressure: `win_sel`=3, `sn_valid` toggling 1/0, all bits 1, `out_ready` held 0 for 5 cycles → result appears after 8 qualified bits, `prob_out`=256, held stable until `out_ready`; `bip_out`=+256.
- Clamp and edge windows: `win_sel`=15 → window of 256 bits, all zeros → `prob_out`=0, `bip_out`=−256. `win_sel`=0 with one 1 bit → `prob_out`=256.
- Continuous mode: `cont`=1, `win_sel`=2, alternating 1010… stream → every window yields `prob_out`=128 (`bip_out`=0). The handshake-cycle bit is dropped, and `start` pulses mid-window are ignored.
- Abort: `rst_n`=0 for one cycle midway through a 256-bit window → IDLE, no `out_valid`. A fresh start then gives a correct count over a full new window.

Source files
------------

// File: rtl/sn_window_decoder.sv
// sn_window_decoder: converts a serial stochastic bitstream back to binary by
// counting ones over a window of 2^L qualified bits. The result is normalised
// to Q0.MAX_LOG2 full-scale and handed out through a valid/ready handshake.
// Optional feature macro: SN_BIPOLAR_EN adds a registered bipolar output
// (2*prob - 2^MAX_LOG2). Without it bip_out is tied to 0.
module sn_window_decoder #(
    parameter int MAX_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sn_bit,
    input  logic                       sn_valid,
    input  logic                       start,
    input  logic                       cont,
    input  logic [3:0]                 win_sel,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MAX_LOG2:0]          prob_out,
    output logic signed [MAX_LOG2+1:0] bip_out
);

    // One extra bit so an all-ones window reaches 2^MAX_LOG2 without wrapping.
    localparam int CW = MAX_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t        state, state_next;
    logic [3:0]    win_len;
    logic [3:0]    win_clamped;
    logic [CW-1:0] bits_seen, ones;
    logic [CW-1:0] bits_next, ones_next;
    logic [CW-1:0] win_target;
    logic [CW-1:0] prob_next;
    logic          cont_q;
    logic          count_en;
    logic          win_end;
    logic          handshake;

    assign win_clamped = (int'(win_sel) > MAX_LOG2) ? 4'(MAX_LOG2) : win_sel;
    assign win_target  = CW'(1) << win_len;
    assign bits_next   = bits_seen + CW'(1);
    assign ones_next   = ones + CW'(sn_bit);
    assign count_en    = (state == COUNT) && sn_valid;
    assign win_end     = count_en && (bits_next == win_target);
    assign handshake   = (state == DONE) && out_ready;
    // Scale the count so every window length shares the same full-scale.
    assign prob_next   = ones_next << (MAX_LOG2 - int'(win_len));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COUNT;
            COUNT:   if (win_end) state_next = DONE;
            DONE:    if (out_ready) state_next = cont_q ? COUNT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counters, window config and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bits_seen <= '0;
            ones      <= '0;
            win_len   <= '0;
            cont_q    <= 1'b0;
            prob_out  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            busy      <= (state_next != IDLE);
            out_valid <= (state_next == DONE);
            if (state == IDLE) begin
                bits_seen <= '0;
                ones      <= '0;
                if (start) win_len <= win_clamped;
            end else if (count_en) begin
                bits_seen <= bits_next;
                ones      <= ones_next;
                if (win_end) begin
                    prob_out <= prob_next;
                    cont_q   <= cont;
                end
            end else if (handshake) begin
                // Re-arm for the next window; bits in this cycle are dropped.
                bits_seen <= '0;
                ones      <= '0;
            end
        end
    end

`ifdef SN_BIPOLAR_EN
    localparam logic [MAX_LOG2+1:0] BIP_OFS = (MAX_LOG2 + 2)'(1) << MAX_LOG2;
    logic [MAX_LOG2+1:0] bip_next;

    // Modular arithmetic gives the right two's-complement result at +2^MAX_LOG2.
    assign bip_next = {prob_next, 1'b0} - BIP_OFS;

    // Bipolar result registered alongside prob_out
    always_ff @(posedge clk) begin
        if (!rst_n)       bip_out <= '0;
        else if (win_end) bip_out <= bip_next;
    end
`else
    assign bip_out = '0;
`endif

endmodule

// File: tb/tb_sn_window_decoder.sv
// Bench for sn_window_decoder (MAX_LOG2=8): table-driven windows plus
// hand-written continuous-mode and abort sequences; results are checked by a
// scoreboard queue popped at each handshake.
module tb_sn_window_decoder;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sn_bit = 1'b0;
    logic              sn_valid = 1'b0;
    logic              start = 1'b0;
    logic              cont = 1'b0;
    logic [3:0]        win_sel = 4'd0;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [8:0]        prob_out;
    logic signed [9:0] bip_out;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int bip_q[$];

    sn_window_decoder #(.MAX_LOG2(8)) dut (
        .clk(clk), .rst_n(rst_n), .sn_bit(sn_bit), .sn_valid(sn_valid),
        .start(start), .cont(cont), .win_sel(win_sel), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .prob_out(prob_out),
        .bip_out(bip_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ws;
        int         ones;
        bit         gap;
        int         rdly;
        int         eprob;
        int         ebip;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bipx(input int b);
`ifdef SN_BIPOLAR_EN
        return b;
`else
        return 0 * b;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each accepted result against the queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got prob %0d expected no result", prob_out);
            end else begin
                chk("prob_out", int'(prob_out), exp_q.pop_front());
                chk("bip_out", int'(bip_out), bip_q.pop_front());
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int n;
        n = 1 << ((v.ws > 4'd8) ? 8 : int'(v.ws));
        win_sel = v.ws; cont = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        win_sel = ~v.ws;
        chk("busy_after_start", int'(busy), 1);
        exp_q.push_back(v.eprob);
        bip_q.push_back(bipx(v.ebip));
        for (int i = 0; i < n; i++) begin
            if (v.gap && i > 0) begin
                sn_valid = 1'b0; sn_bit = 1'b1;
                step();
            end
            if (out_valid) chk("valid_early", int'(out_valid), 0);
            sn_valid = 1'b1; sn_bit = (i < v.ones);
            step();
        end
        sn_valid = 1'b0; sn_bit = 1'b0;
        chk("result_latency", int'(out_valid), 1);
        for (int k = 0; k < v.rdly; k++) begin
            out_ready = 1'b0;
            step();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_prob", int'(prob_out), v.eprob);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("valid_cleared", int'(out_valid), 0);
        chk("busy_cleared", int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{ws: 4'd4,  ones: 5,   gap: 1'b0, rdly: 0, eprob: 80,  ebip: -96};
        vecs[1] = '{ws: 4'd3,  ones: 8,   gap: 1'b1, rdly: 5, eprob: 256, ebip: 256};
        vecs[2] = '{ws: 4'd15, ones: 0,   gap: 1'b0, rdly: 0, eprob: 0,   ebip: -256};
        vecs[3] = '{ws: 4'd0,  ones: 1,   gap: 1'b0, rdly: 1, eprob: 256, ebip: 256};
        vecs[4] = '{ws: 4'd0,  ones: 0,   gap: 1'b0, rdly: 0, eprob: 0,   ebip: -256};
        vecs[5] = '{ws: 4'd8,  ones: 256, gap: 1'b0, rdly: 2, eprob: 256, ebip: 256};
        vecs[6] = '{ws: 4'd2,  ones: 3,   gap: 1'b1, rdly: 0, eprob: 192, ebip: 128};
        vecs[7] = '{ws: 4'd5,  ones: 17,  gap: 1'b0, rdly: 3, eprob: 136, ebip: 16};

        // Reset then idle
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_busy", int'(busy), 0);
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_prob", int'(prob_out), 0);
            chk("rst_bip", int'(bip_out), 0);
        end

        // Table-driven windows
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Continuous mode: 1010 windows, dead-cycle bit and mid-window starts ignored
        win_sel = 4'd2; cont = 1'b1; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            exp_q.push_back(128);
            bip_q.push_back(bipx(0));
            for (int i = 0; i < 4; i++) begin
                sn_valid = 1'b1; sn_bit = (i % 2 == 0);
                start = (i == 1); cont = (w < 2);
                step();
            end
            start = 1'b0;
            chk("cont_valid", int'(out_valid), 1);
            sn_valid = 1'b1; sn_bit = 1'b1; start = 1'b1;
            step();
            start = 1'b0;
            chk("cont_busy", int'(busy), (w < 2) ? 1 : 0);
        end
        sn_valid = 1'b0; sn_bit = 1'b0; out_ready = 1'b0; cont = 1'b0;
        step();
        chk("cont_idle_valid", int'(out_valid), 0);

        // Abort mid-window via reset
        win_sel = 4'd8; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sn_valid = 1'b1; sn_bit = 1'b1;
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_prob", int'(prob_out), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) step();
        out_ready = 1'b0; sn_valid = 1'b0;
        chk("abort_still_idle", int'(busy), 0);
        run_vec('{ws: 4'd8, ones: 37, gap: 1'b0, rdly: 0, eprob: 37, ebip: -182});

        step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
